// File: rtl/pipe_hazard_tracker_pkg.sv
// Shared hazard-interface constants: tag widths and hazard op-type encodings.
// Also used by the hazard detection unit, so both ends agree on the encoding.
package pipe_hazard_tracker_pkg;

  localparam int REG_AW   = 5;
  localparam int OPTYPE_W = 2;

  localparam logic [OPTYPE_W-1:0] OPT_NONE  = 2'b00;
  localparam logic [OPTYPE_W-1:0] OPT_ALU   = 2'b01;
  localparam logic [OPTYPE_W-1:0] OPT_LOAD  = 2'b10;
  localparam logic [OPTYPE_W-1:0] OPT_STORE = 2'b11;

endpackage

// File: rtl/pipe_hazard_tracker_stage_reg.sv
// hazard_stage_reg: generic tag register, 1-cycle latency; flush beats enable, enable beats hold.
// A flush loads an all-zero bubble even while enable is low.
module hazard_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         flush,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out
);

  logic [W-1:0] stage_q;
  logic [W-1:0] stage_d;

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (en) begin
      stage_d = data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign data_out = stage_q;

endmodule

// File: rtl/pipe_hazard_tracker.sv
// Tracks rd/rs2/op-type/valid of the EXE, MEM and WB instructions, 1 cycle per stage, all outputs registered.
// HAZARD_PERF_EN adds saturating bubble/flush counters; without it those ports are tied to 0.
module pipe_hazard_tracker
  import pipe_hazard_tracker_pkg::*;
#(
  parameter int REG_AW   = pipe_hazard_tracker_pkg::REG_AW,
  parameter int OPTYPE_W = pipe_hazard_tracker_pkg::OPTYPE_W,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_ID,
  input  logic [REG_AW-1:0]   rd_ID,
  input  logic [REG_AW-1:0]   rs2_ID,
  input  logic                we_ID,
  input  logic [OPTYPE_W-1:0] hazard_optype_ID,
  input  logic                reg_DE_EN,
  input  logic                reg_DE_flush,
  input  logic                reg_EM_EN,
  input  logic                reg_EM_flush,
  input  logic                reg_MW_EN,
  output logic [REG_AW-1:0]   rd_EXE,
  output logic [REG_AW-1:0]   rd_MEM,
  output logic [REG_AW-1:0]   rd_WB,
  output logic [REG_AW-1:0]   rs2_EXE,
  output logic [OPTYPE_W-1:0] optype_EXE,
  output logic [OPTYPE_W-1:0] optype_MEM,
  output logic                valid_EXE,
  output logic                valid_MEM,
  output logic                valid_WB,
  output logic [CNT_W-1:0]    bubble_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  localparam int DE_W = 1 + 2*REG_AW + OPTYPE_W;
  localparam int EM_W = 1 + REG_AW + OPTYPE_W;
  localparam int MW_W = 1 + REG_AW;

  logic [REG_AW-1:0] rd_eff_ID;
  logic [DE_W-1:0]   de_in, de_out;
  logic [EM_W-1:0]   em_in, em_out;
  logic [MW_W-1:0]   mw_in, mw_out;

  // Non-writers, x0 writers and empty slots all carry tag 0, so a nonzero
  // tag downstream always means a real register write.
  always_comb begin
    rd_eff_ID = '0;
    if (valid_ID && we_ID && (rd_ID != '0)) begin
      rd_eff_ID = rd_ID;
    end
  end

  assign de_in = {valid_ID, rd_eff_ID, rs2_ID, hazard_optype_ID};
  assign em_in = {valid_EXE, rd_EXE, optype_EXE};
  assign mw_in = {valid_MEM, rd_MEM};

  hazard_stage_reg #(.W(DE_W)) u_de (
    .clk      (clk),
    .rst      (rst),
    .en       (reg_DE_EN),
    .flush    (reg_DE_flush),
    .data_in  (de_in),
    .data_out (de_out)
  );

  hazard_stage_reg #(.W(EM_W)) u_em (
    .clk      (clk),
    .rst      (rst),
    .en       (reg_EM_EN),
    .flush    (reg_EM_flush),
    .data_in  (em_in),
    .data_out (em_out)
  );

  hazard_stage_reg #(.W(MW_W)) u_mw (
    .clk      (clk),
    .rst      (rst),
    .en       (reg_MW_EN),
    .flush    (1'b0),
    .data_in  (mw_in),
    .data_out (mw_out)
  );

  assign {valid_EXE, rd_EXE, rs2_EXE, optype_EXE} = de_out;
  assign {valid_MEM, rd_MEM, optype_MEM}          = em_out;
  assign {valid_WB, rd_WB}                        = mw_out;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (reg_DE_flush && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
    if (reg_EM_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`else
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// Directed bench for pipe_hazard_tracker: stimulus queues expected stage state, a negedge monitor compares.
module tb_pipe_hazard_tracker;

  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           valid_ID = 1'b0;
  logic [4:0]     rd_ID = '0;
  logic [4:0]     rs2_ID = '0;
  logic           we_ID = 1'b0;
  logic [1:0]     hazard_optype_ID = '0;
  logic           reg_DE_EN = 1'b0, reg_DE_flush = 1'b0;
  logic           reg_EM_EN = 1'b0, reg_EM_flush = 1'b0, reg_MW_EN = 1'b0;
  logic [4:0]     rd_EXE, rd_MEM, rd_WB, rs2_EXE;
  logic [1:0]     optype_EXE, optype_MEM;
  logic           valid_EXE, valid_MEM, valid_WB;
  logic [CW-1:0]  bubble_cnt, flush_cnt;

  pipe_hazard_tracker #(.REG_AW(5), .OPTYPE_W(2), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .valid_ID(valid_ID), .rd_ID(rd_ID), .rs2_ID(rs2_ID),
    .we_ID(we_ID), .hazard_optype_ID(hazard_optype_ID),
    .reg_DE_EN(reg_DE_EN), .reg_DE_flush(reg_DE_flush),
    .reg_EM_EN(reg_EM_EN), .reg_EM_flush(reg_EM_flush), .reg_MW_EN(reg_MW_EN),
    .rd_EXE(rd_EXE), .rd_MEM(rd_MEM), .rd_WB(rd_WB), .rs2_EXE(rs2_EXE),
    .optype_EXE(optype_EXE), .optype_MEM(optype_MEM),
    .valid_EXE(valid_EXE), .valid_MEM(valid_MEM), .valid_WB(valid_WB),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    tag;
    string nm;
    int    v_e, rd_e, rs2_e, op_e, v_m, rd_m, op_m, v_w, rd_w, bub, fl;
  } exp_t;

  exp_t exp_q[$];
  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  int   m_bub = 0;
  int   m_fl = 0;

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string nm, input string fld, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].tag <= edge_cnt) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.nm, "valid_EXE",  int'(valid_EXE),  e.v_e);
      chk(e.nm, "rd_EXE",     int'(rd_EXE),     e.rd_e);
      chk(e.nm, "rs2_EXE",    int'(rs2_EXE),    e.rs2_e);
      chk(e.nm, "optype_EXE", int'(optype_EXE), e.op_e);
      chk(e.nm, "valid_MEM",  int'(valid_MEM),  e.v_m);
      chk(e.nm, "rd_MEM",     int'(rd_MEM),     e.rd_m);
      chk(e.nm, "optype_MEM", int'(optype_MEM), e.op_m);
      chk(e.nm, "valid_WB",   int'(valid_WB),   e.v_w);
      chk(e.nm, "rd_WB",      int'(rd_WB),      e.rd_w);
      chk(e.nm, "bubble_cnt", int'(bubble_cnt), e.bub);
      chk(e.nm, "flush_cnt",  int'(flush_cnt),  e.fl);
    end
  end

  // ctl = {DE_EN, DE_flush, EM_EN, EM_flush, MW_EN}; ev = {valid_EXE, valid_MEM, valid_WB}
  task automatic step(input string nm, input bit r, input bit v, input int rd, input int rs2,
                      input bit w, input int op, input bit [4:0] ctl, input bit [2:0] ev,
                      input int erd_e, input int erd_m, input int erd_w,
                      input int ers2_e, input int eop_e, input int eop_m);
    exp_t e;
    @(negedge clk);
    rst = r; valid_ID = v; rd_ID = 5'(rd); rs2_ID = 5'(rs2); we_ID = w;
    hazard_optype_ID = 2'(op);
    {reg_DE_EN, reg_DE_flush, reg_EM_EN, reg_EM_flush, reg_MW_EN} = ctl;
    if (r) begin
      m_bub = 0;
      m_fl  = 0;
    end else begin
      if (ctl[3] && m_bub < (1 << CW) - 1) m_bub++;
      if (ctl[1] && m_fl  < (1 << CW) - 1) m_fl++;
    end
    e.tag = edge_cnt + 1;
    e.nm  = nm;
    e.v_e = int'(ev[2]); e.v_m = int'(ev[1]); e.v_w = int'(ev[0]);
    e.rd_e = erd_e; e.rd_m = erd_m; e.rd_w = erd_w;
    e.rs2_e = ers2_e; e.op_e = eop_e; e.op_m = eop_m;
`ifdef HAZARD_PERF_EN
    e.bub = m_bub;
    e.fl  = m_fl;
`else
    e.bub = 0;
    e.fl  = 0;
`endif
    exp_q.push_back(e);
  endtask

  localparam bit [4:0] ADV = 5'b10101;

  initial begin
    step("rst0", 1, 1'($urandom), 31 & $urandom, 31 & $urandom, 1'($urandom), 3 & $urandom,
         5'($urandom), 3'b000, 0, 0, 0, 0, 0, 0);
    step("rst1", 1, 1'($urandom), 31 & $urandom, 31 & $urandom, 1'($urandom), 3 & $urandom,
         5'($urandom), 3'b000, 0, 0, 0, 0, 0, 0);
    step("alu5",    0, 1, 5,  0,  1, 1, ADV,      3'b100, 5,  0,  0,  0,  1, 0);
    step("x0",      0, 1, 0,  0,  1, 1, ADV,      3'b110, 0,  5,  0,  0,  1, 1);
    step("nonwr",   0, 1, 7,  0,  0, 0, ADV,      3'b111, 0,  0,  5,  0,  0, 1);
    step("load3",   0, 1, 3,  0,  1, 2, ADV,      3'b111, 3,  0,  0,  0,  2, 0);
    step("luflush", 0, 1, 4,  0,  1, 1, 5'b11101, 3'b011, 0,  3,  0,  0,  0, 2);
    step("alu9",    0, 1, 9,  1,  1, 1, ADV,      3'b101, 9,  0,  3,  1,  1, 0);
    step("stall1",  0, 1, 10, 2,  1, 1, 5'b00001, 3'b100, 9,  0,  0,  1,  1, 0);
    step("stall2",  0, 1, 10, 2,  1, 1, 5'b00001, 3'b100, 9,  0,  0,  1,  1, 0);
    step("stallfl", 0, 1, 10, 2,  1, 1, 5'b01101, 3'b010, 0,  9,  0,  0,  0, 1);
    step("emflush", 0, 1, 11, 0,  1, 1, 5'b10011, 3'b101, 11, 0,  9,  0,  1, 0);
    step("store",   0, 1, 12, 12, 0, 3, ADV,      3'b110, 0,  11, 0,  12, 3, 1);
    step("alu13",   0, 1, 13, 0,  1, 1, ADV,      3'b111, 13, 0,  11, 0,  1, 3);
    step("mwhold",  0, 1, 14, 5,  1, 2, 5'b10100, 3'b111, 14, 13, 11, 5,  2, 1);
    step("store2",  0, 1, 12, 12, 0, 3, ADV,      3'b111, 0,  14, 13, 12, 3, 2);
    step("midrst",  1, 1, 6,  4,  1, 1, ADV,      3'b000, 0,  0,  0,  0,  0, 0);
    step("alu6",    0, 1, 6,  0,  1, 1, ADV,      3'b100, 6,  0,  0,  0,  1, 0);
    for (int i = 0; i < 20; i++) begin
      step($sformatf("sat%0d", i), 0, 1, 8, 0, 1, 1, 5'b11101,
           {1'b0, i == 0, i == 1}, 0, (i == 0) ? 6 : 0, (i == 1) ? 6 : 0, 0, 0, (i == 0) ? 1 : 0);
    end
    step("emfl2",   0, 1, 2,  0,  1, 1, 5'b10111, 3'b100, 2,  0,  0,  0,  1, 0);
    step("emfl3",   0, 1, 2,  0,  1, 1, 5'b10111, 3'b100, 2,  0,  0,  0,  1, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
